// File: rtl/focus_metric_accumulator.sv
// Frame-level focus metric: accumulates thresholded edge energy inside a fixed ROI and publishes score/count/peak at each VS fall.
// Optional ROI perimeter overlay output is built only when FOCUS_OVERLAY_EN is defined.
`timescale 1ns/1ps
module focus_metric_accumulator #(
   parameter int WIDTH  = 800,
   parameter int HEIGHT = 480,
   parameter int ROI_X0 = 200,
   parameter int ROI_Y0 = 120,
   parameter int ROI_W  = 400,
   parameter int ROI_H  = 240,
   parameter int THRESH = 16,
   parameter int SUM_W  = 32
) (
   input  logic             VGA_CLK,
   input  logic             reset_n,
   input  logic             iVGA_VS,
   input  logic             iVGA_BLANK_N,
   input  logic [7:0]       edge_in,
   input  logic             enable,
   input  logic             peak_clear,
   output logic [SUM_W-1:0] score,
   output logic [19:0]      edge_count,
   output logic             score_valid,
   output logic [SUM_W-1:0] peak_score,
   output logic             peak_update,
   output logic             overflow,
   output logic             frame_err,
   output logic             roi_border
);

   // Counters carry headroom so oversized lines/frames are detectable rather than wrapping.
   localparam int X_W = $clog2(WIDTH + 2) + 1;
   localparam int Y_W = $clog2(HEIGHT + 2) + 1;

   localparam logic [X_W-1:0] WIDTH_C   = X_W'(WIDTH);
   localparam logic [X_W-1:0] ROI_XLO_C = X_W'(ROI_X0);
   localparam logic [X_W-1:0] ROI_XHI_C = X_W'(ROI_X0 + ROI_W - 1);
   localparam logic [X_W-1:0] X_MAX_C   = '1;
   localparam logic [Y_W-1:0] HEIGHT_C  = Y_W'(HEIGHT);
   localparam logic [Y_W-1:0] ROI_YLO_C = Y_W'(ROI_Y0);
   localparam logic [Y_W-1:0] ROI_YHI_C = Y_W'(ROI_Y0 + ROI_H - 1);
   localparam logic [Y_W-1:0] Y_MAX_C   = '1;
   localparam logic [7:0]     THRESH_C  = 8'(THRESH);

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   // Returns {carry, saturated sum}; carry marks that the sum clipped.
   function automatic logic [SUM_W:0] sat_acc(input logic [SUM_W-1:0] a,
                                               input logic [7:0]       e);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W - 7){1'b0}}, e};
      if (s[SUM_W]) begin
         sat_acc = {1'b1, {SUM_W{1'b1}}};
      end else begin
         sat_acc = s;
      end
   endfunction

   function automatic logic [19:0] sat_cnt(input logic [19:0] c);
      if (c == 20'hFFFFF) begin
         sat_cnt = c;
      end else begin
         sat_cnt = c + 20'd1;
      end
   endfunction

   state_t           state_q, state_d;
   logic             vs_prev_q, blank_prev_q;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [19:0]      cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             geo_err_q, geo_err_d;
   logic [SUM_W-1:0] score_q, score_d;
   logic [19:0]      count_q, count_d;
   logic             valid_q, valid_d;
   logic [SUM_W-1:0] peak_q, peak_d;
   logic             upd_q, upd_d;
   logic             ovf_out_q, ovf_out_d;
   logic             err_q, err_d;

   logic             frame_end, blank_fall, active;
   logic             in_xrange, in_yrange, hit;
   logic             x_bad, y_bad, geo_bad;
   logic [SUM_W-1:0] peak_base;
   logic [SUM_W:0]   acc_sum;

   assign frame_end  = !iVGA_VS && vs_prev_q;
   assign blank_fall = blank_prev_q && !iVGA_BLANK_N;
   assign active     = iVGA_VS && iVGA_BLANK_N;
   assign in_xrange  = (x_q >= ROI_XLO_C) && (x_q <= ROI_XHI_C);
   assign in_yrange  = (y_q >= ROI_YLO_C) && (y_q <= ROI_YHI_C);
   assign hit        = active && in_xrange && in_yrange && (edge_in >= THRESH_C);
   assign x_bad      = active && (x_q >= WIDTH_C);
   assign y_bad      = active && (y_q >= HEIGHT_C);
   // At frame end y holds the number of completed lines.
   assign geo_bad    = geo_err_q || (y_q != HEIGHT_C);
   assign peak_base  = peak_clear ? '0 : peak_q;
   assign acc_sum    = sat_acc(acc_q, edge_in);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!iVGA_VS) begin
         x_d = '0;
         y_d = '0;
      end else if (blank_fall) begin
         x_d = '0;
         if (y_q != Y_MAX_C) begin
            y_d = y_q + 1'b1;
         end
      end else if (iVGA_BLANK_N && (x_q != X_MAX_C)) begin
         x_d = x_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      geo_err_d = geo_err_q;
      score_d   = score_q;
      count_d   = count_q;
      ovf_out_d = ovf_out_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      upd_d     = 1'b0;
      peak_d    = peak_base;
      if (!enable) begin
         state_d = SYNC;
      end else begin
         case (state_q)
            SYNC: begin
               if (frame_end) begin
                  state_d   = ACCUM;
                  acc_d     = '0;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
                  geo_err_d = 1'b0;
               end
            end
            ACCUM: begin
               if (frame_end) begin
                  state_d = PUBLISH;
                  if (!geo_bad) begin
                     score_d   = acc_q;
                     count_d   = cnt_q;
                     ovf_out_d = ovf_q;
                     valid_d   = 1'b1;
                     if (acc_q > peak_base) begin
                        peak_d = acc_q;
                        upd_d  = 1'b1;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
                  acc_d     = '0;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
                  geo_err_d = 1'b0;
               end else begin
                  if (hit) begin
                     acc_d = acc_sum[SUM_W-1:0];
                     ovf_d = ovf_q | acc_sum[SUM_W];
                     cnt_d = sat_cnt(cnt_q);
                  end
                  if (x_bad || y_bad) begin
                     geo_err_d = 1'b1;
                  end
               end
            end
            PUBLISH: begin
               state_d = ACCUM;
            end
            default: begin
               state_d = SYNC;
            end
         endcase
      end
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= SYNC;
         vs_prev_q    <= 1'b0;
         blank_prev_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         geo_err_q    <= 1'b0;
         score_q      <= '0;
         count_q      <= '0;
         valid_q      <= 1'b0;
         peak_q       <= '0;
         upd_q        <= 1'b0;
         ovf_out_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_prev_q    <= iVGA_VS;
         blank_prev_q <= iVGA_BLANK_N;
         x_q          <= x_d;
         y_q          <= y_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         geo_err_q    <= geo_err_d;
         score_q      <= score_d;
         count_q      <= count_d;
         valid_q      <= valid_d;
         peak_q       <= peak_d;
         upd_q        <= upd_d;
         ovf_out_q    <= ovf_out_d;
         err_q        <= err_d;
      end
   end

   assign score       = score_q;
   assign edge_count  = count_q;
   assign score_valid = valid_q;
   assign peak_score  = peak_q;
   assign peak_update = upd_q;
   assign overflow    = ovf_out_q;
   assign frame_err   = err_q;

`ifdef FOCUS_OVERLAY_EN
   logic border_q, border_d;

   // Perimeter of the ROI box: top/bottom rows across the ROI columns, left/right columns down the ROI lines.
   assign border_d = active &&
                     ((in_xrange && ((y_q == ROI_YLO_C) || (y_q == ROI_YHI_C))) ||
                      (in_yrange && ((x_q == ROI_XLO_C) || (x_q == ROI_XHI_C))));

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         border_q <= 1'b0;
      end else begin
         border_q <= border_d;
      end
   end

   assign roi_border = border_q;
`else
   assign roi_border = 1'b0;
`endif

endmodule

// File: tb/tb_focus_metric_accumulator.sv
// Randomized frame-level bench for focus_metric_accumulator with a per-cycle compare against a behavioural frame model.
`timescale 1ns/1ps
module tb_focus_metric_accumulator;
   localparam int WIDTH = 8, HEIGHT = 4, RX0 = 2, RY0 = 1, RW = 4, RH = 2, THR = 16, SW = 8;
   localparam int SMAX = (1 << SW) - 1;
`ifdef FOCUS_OVERLAY_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, vs, bl, en, clr;
   logic [7:0]    e;
   logic [SW-1:0] score, peak_score;
   logic [19:0]   edge_count;
   logic          score_valid, peak_update, overflow, frame_err, roi_border;

   always #5 clk = ~clk;

   focus_metric_accumulator #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROI_X0(RX0), .ROI_Y0(RY0),
      .ROI_W(RW), .ROI_H(RH), .THRESH(THR), .SUM_W(SW)
   ) dut (
      .VGA_CLK(clk), .reset_n(rst_n), .iVGA_VS(vs), .iVGA_BLANK_N(bl),
      .edge_in(e), .enable(en), .peak_clear(clr),
      .score(score), .edge_count(edge_count), .score_valid(score_valid),
      .peak_score(peak_score), .peak_update(peak_update), .overflow(overflow),
      .frame_err(frame_err), .roi_border(roi_border)
   );

   int n_chk = 0, n_pass = 0;
   bit chk_en = 1'b0;

   // Model state: expected outputs plus frame-level bookkeeping.
   int exp_score, exp_cnt, exp_peak;
   bit exp_valid, exp_upd, exp_ovf, exp_err, exp_border;
   bit armed;
   int fsum, fcnt;
   bit fgood;
   int cap_valid, cap_score, cap_cnt, cap_peak, cap_upd, cap_ovf, cap_err;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("score", score, exp_score);
         chk("edge_count", edge_count, exp_cnt);
         chk("score_valid", score_valid, exp_valid);
         chk("peak_score", peak_score, exp_peak);
         chk("peak_update", peak_update, exp_upd);
         chk("overflow", overflow, exp_ovf);
         chk("frame_err", frame_err, exp_err);
         chk("roi_border", roi_border, exp_border);
      end
   end

   task automatic model_zero();
      exp_score = 0; exp_cnt = 0; exp_peak = 0;
      exp_valid = 0; exp_upd = 0; exp_ovf = 0; exp_err = 0; exp_border = 0;
      armed = 0;
   endtask

   function automatic bit on_border(input int l, input int c);
      bit colr, rowr;
      colr = (c >= RX0) && (c < RX0 + RW);
      rowr = (l >= RY0) && (l < RY0 + RH);
      return OVL && ((colr && (l == RY0 || l == RY0 + RH - 1)) ||
                     (rowr && (c == RX0 || c == RX0 + RW - 1)));
   endfunction

   function automatic int pix(input int mode, input int val, input int c);
      if (mode == 0) return val;
      if (mode == 1) return (c % 2 == 0) ? val : 10;
      return int'($urandom_range(0, 60));
   endfunction

   // One clock: drive inputs, let the edge pass, then advance the model to the post-edge outputs.
   task automatic step(input bit v, input bit b, input int ev, input bit c, input bit is_fe, input bit brd);
      int base;
      vs = v; bl = b; e = 8'(ev); clr = c;
      @(posedge clk); #1;
      exp_valid = 0; exp_upd = 0; exp_err = 0;
      if (!rst_n) begin
         model_zero();
      end else begin
         exp_border = brd;
         if (is_fe && en && armed) begin
            if (fgood) begin
               exp_score = (fsum > SMAX) ? SMAX : fsum;
               exp_ovf   = (fsum > SMAX);
               exp_cnt   = (fcnt > 20'hFFFFF) ? 20'hFFFFF : fcnt;
               exp_valid = 1;
               base = c ? 0 : exp_peak;
               if (exp_score > base) begin
                  exp_peak = exp_score;
                  exp_upd  = 1;
               end else begin
                  exp_peak = base;
               end
            end else begin
               exp_err = 1;
               if (c) exp_peak = 0;
            end
         end else if (c) begin
            exp_peak = 0;
         end
         if (!en) armed = 0;
         else if (is_fe) armed = 1;
      end
   endtask

   task automatic frame(input int nl, input int wide_line, input int mode, input int val,
                        input int drop_line, input bit clr_end, input int rst_line, input int clr_pct);
      int v, np;
      bit ce;
      en = 1; fsum = 0; fcnt = 0;
      fgood = (nl == HEIGHT) && (wide_line < 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int l = 0; l < nl; l++) begin
         if (l == drop_line) en = 0;
         np = (l == wide_line) ? WIDTH + 1 : WIDTH;
         for (int c = 0; c < np; c++) begin
            v = pix(mode, val, c);
            if (l >= RY0 && l < RY0 + RH && c >= RX0 && c < RX0 + RW && v >= THR) begin
               fsum += v;
               fcnt++;
            end
            ce = (int'($urandom_range(0, 99)) < clr_pct);
            step(1, 1, v, ce, 0, on_border(l, c));
            if (l == rst_line && c == 3) begin
               #2 rst_n = 0;
               #1;
               chk("arst_score", score, 0);
               chk("arst_edge_count", edge_count, 0);
               chk("arst_valid", score_valid, 0);
               chk("arst_peak", peak_score, 0);
               chk("arst_update", peak_update, 0);
               chk("arst_overflow", overflow, 0);
               chk("arst_frame_err", frame_err, 0);
               chk("arst_border", roi_border, 0);
               model_zero();
            end
         end
         step(1, 0, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, 0);
      end
      step(0, 0, 0, clr_end, 1, 0);
      cap_valid = score_valid; cap_score = score; cap_cnt = edge_count;
      cap_peak = peak_score; cap_upd = peak_update; cap_ovf = overflow; cap_err = frame_err;
      if (rst_line >= 0) rst_n = 1;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int r, nl, wide, drop;
      rst_n = 0; vs = 0; bl = 0; e = 0; en = 1; clr = 0;
      model_zero();
      fsum = 0; fcnt = 0; fgood = 0;
      step(0, 0, 0, 0, 0, 0);
      chk_en = 1;
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1;
      step(0, 0, 0, 0, 0, 0);
      chk("rst_score", score, 0);
      chk("rst_peak", peak_score, 0);

      // Threshold: first frame only arms, second publishes nothing above threshold.
      frame(4, -1, 0, 10, -1, 0, -1, 0);
      chk("sync_no_publish", cap_valid, 0);
      frame(4, -1, 0, 10, -1, 0, -1, 0);
      chk("thr_valid", cap_valid, 1);
      chk("thr_score", cap_score, 0);
      chk("thr_count", cap_cnt, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("e20_score", cap_score, 160);
      chk("e20_count", cap_cnt, 8);
      chk("e20_peak", cap_peak, 160);
      chk("e20_update", cap_upd, 1);

      // Peak hold.
      frame(4, -1, 1, 20, -1, 0, -1, 0);
      chk("hold_score", cap_score, 80);
      chk("hold_count", cap_cnt, 4);
      chk("hold_peak", cap_peak, 160);
      chk("hold_update", cap_upd, 0);

      // Saturation then recovery.
      frame(4, -1, 0, 40, -1, 0, -1, 0);
      chk("sat_score", cap_score, 255);
      chk("sat_overflow", cap_ovf, 1);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("unsat_score", cap_score, 160);
      chk("unsat_overflow", cap_ovf, 0);

      // Geometry: five lines.
      frame(5, -1, 0, 20, -1, 0, -1, 0);
      chk("geo_err", cap_err, 1);
      chk("geo_valid", cap_valid, 0);
      chk("geo_score_held", cap_score, 160);
      frame(4, 1, 0, 30, -1, 0, -1, 0);
      chk("wide_err", cap_err, 1);

      // Standalone clear, then coincident clear on an 80 frame.
      step(0, 0, 0, 1, 0, 0);
      chk("clear_peak", peak_score, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("repeak", cap_peak, 160);
      frame(4, -1, 1, 20, -1, 1, -1, 0);
      chk("coclr_peak", cap_peak, 80);
      chk("coclr_update", cap_upd, 1);

      // Enable dropped mid-frame: no publish, next frame re-arms, the one after publishes.
      frame(4, -1, 0, 20, 1, 0, -1, 0);
      chk("drop_no_pub", cap_valid, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("rearm_no_pub", cap_valid, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("rearm_pub", cap_valid, 1);

      // Mid-frame asynchronous reset.
      frame(4, -1, 0, 20, -1, 0, 2, 0);
      chk("rst_frame_no_pub", cap_valid, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("post_rst_sync", cap_valid, 0);
      frame(4, -1, 0, 20, -1, 0, -1, 0);
      chk("post_rst_pub", cap_valid, 1);
      chk("post_rst_score", cap_score, 160);

      for (int f = 0; f < 140; f++) begin
         r = int'($urandom_range(0, 99));
         nl = (r < 4) ? 5 : (r < 7) ? 3 : 4;
         wide = (r >= 7 && r < 10) ? int'($urandom_range(0, 3)) : -1;
         drop = (int'($urandom_range(0, 99)) < 6) ? int'($urandom_range(0, 3)) : -1;
         frame(nl, wide, 2, 0, drop, ($urandom_range(0, 9) == 0), -1, 2);
      end

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/focus_metric_accumulator.md
Name: focus_metric_accumulator

Overview:
- Downstream consumer of the convolution filter's 8-bit edge stream (Sobel magnitude) and its aligned VGA timing signals.
- Accumulates edge energy inside a programmable region of interest (ROI) over each frame.
- At each frame end it publishes a sharpness score, an over-threshold pixel count and a running peak.
- The peak is the metric the auto-focus controller (KEY[3]/SW[9] mode) hill-climbs on.

Parameters:
- WIDTH, 800: active pixels per line.
- HEIGHT, 480: active lines per frame.
- ROI_X0, 200: first ROI column, inclusive.
- ROI_Y0, 120: first ROI line, inclusive.
- ROI_W, 400: ROI width in pixels.
- ROI_H, 240: ROI height in lines.
- THRESH, 16: minimum edge value that is accumulated.
- SUM_W, 32: width of the score and peak accumulators.

Ports:
- VGA_CLK  in  1  pixel clock (25 MHz).
- reset_n  in  1  asynchronous active-low reset.
- iVGA_VS  in  1  vertical sync, low between frames.
- iVGA_BLANK_N  in  1  high during active pixels.
- edge_in  in  8  unsigned edge magnitude, aligned with the sync inputs.
- enable  in  1  metric enable.
- peak_clear  in  1  one-cycle pulse that zeroes the peak.
- score  out  SUM_W  last published frame score.
- edge_count  out  20  over-threshold ROI pixels in the last published frame.
- score_valid  out  1  one-cycle publish pulse.
- peak_score  out  SUM_W  largest score since reset or peak_clear.
- peak_update  out  1  one-cycle pulse when peak_score changed due to a publish.
- overflow  out  1  last published score saturated.
- frame_err  out  1  one-cycle pulse: frame geometry violation.
- roi_border  out  1  ROI perimeter flag, used for overlay.

Behaviour:
- Reset: all outputs, counters and accumulators are 0; state is SYNC.
- Clocking: all logic runs on VGA_CLK posedge; reset_n is asynchronous.
- Position counters:
  - x increments on each cycle with iVGA_BLANK_N=1.
  - The falling edge of BLANK_N (registered previous value 1, current 0) sets x=0 and increments y.
  - iVGA_VS=0 holds x=0 and y=0.
- Frame-end event: the cycle where iVGA_VS=0 and the registered vs_prev=1.
- States:
  - SYNC: no accumulation. On a frame-end event with enable=1, go to ACCUM with accumulators cleared; publish nothing.
  - ACCUM: accumulate every active pixel with ROI_X0 <= x < ROI_X0+ROI_W, ROI_Y0 <= y < ROI_Y0+ROI_H and edge_in >= THRESH:
    - acc += edge_in, saturating at 2^SUM_W-1; saturation sets a sticky ovf flag.
    - cnt += 1, saturating at 2^20-1.
    - On a frame-end event, go to PUBLISH.
  - PUBLISH (exactly one cycle):
    - If geometry is good: score<=acc, edge_count<=cnt, overflow<=ovf, score_valid=1.
    - Otherwise: frame_err=1 and score, edge_count, overflow are held.
    - Clear acc, cnt, ovf; return to ACCUM.
- Geometry is bad if any of these occurred during the frame:
  - x reached WIDTH while BLANK_N=1;
  - y reached HEIGHT;
  - the line count at frame end is not HEIGHT.
- Output timing: score_valid or frame_err asserts on the clock edge after the frame-end event cycle, i.e. 1-cycle latency.
- Peak:
  - During the PUBLISH cycle with good geometry, if score_new > peak, peak_score<=score_new and peak_update=1 in the same cycle as score_valid.
  - peak_clear sets peak to 0.
  - If peak_clear coincides with PUBLISH, the comparison uses 0, so any nonzero score becomes the peak.
- enable=0: from any state go to SYNC immediately. Accumulation stops, the partial frame is discarded, and no publish occurs. Outputs hold.
- Mid-operation reset: immediately returns to the reset values.
- Register every output; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: FOCUS_OVERLAY_EN.
- Defined: roi_border=1, registered with 1-cycle latency, for active pixels where x is in the ROI column range and y is ROI_Y0 or ROI_Y0+ROI_H-1, or y is in the ROI line range and x is ROI_X0 or ROI_X0+ROI_W-1. Upstream muxes it into the RGB output to show the focus box.
- Undefined: roi_border is tied to 0 and the comparators are not built.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4, ROI_X0=2, ROI_Y0=1, ROI_W=4, ROI_H=2, THRESH=16, and frames of 4 lines × 8 active pixels between VS pulses.
- Reset: assert reset_n=0 mid-frame -> every output is 0 asynchronously. After release, the first complete frame publishes nothing (SYNC); the second frame publishes.
- Threshold: edge_in=10 for a full frame -> score=0, edge_count=0, score_valid pulse 1 cycle after the VS fall. edge_in=20 -> score=160, edge_count=8, peak_score=160, peak_update=1.
- Peak hold: frames scoring 160 then 80 -> second publish gives score=80, peak_score stays 160, peak_update=0.
- Saturation: SUM_W=8, edge_in=40 -> score=255, overflow=1. Next frame with edge_in=20 -> score=160, overflow=0.
- Geometry: a frame with 5 lines -> frame_err pulses, score_valid=0, score is held at its previous value.
- Coincident clear: peak=160, peak_clear asserted in the PUBLISH cycle of an 80-score frame -> peak_score=80, peak_update=1. enable dropped mid-frame -> no publish for that frame.
